// File: rtl/udp_pkt_pkg.sv
// udp_pkt_pkg
//   Shared definitions for the UDP sample packetizer:
//   - pkt_state_t : serializer state (IDLE, HDR, DATA)
//   - HDR_BYTES   : size of the big-endian sequence-number header
//   - payload_len : UDP payload size in bytes for a given frame geometry.
//                   The UDP length field is payload_len() + 8.
package udp_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } pkt_state_t;

    localparam int unsigned HDR_BYTES = 4;

    function automatic int unsigned payload_len(input int unsigned samples,
                                                input int unsigned sample_bytes);
        return HDR_BYTES + samples * sample_bytes;
    endfunction

endpackage

// File: rtl/udp_sample_packetizer.sv
// udp_sample_packetizer
//   Packs ADC sample words into UDP payload frames on an 8-bit AXI-Stream.
//   Frame layout: 4-byte big-endian sequence number, then SAMPLES_PER_FRAME
//   samples, each sent MSB byte first. tlast marks the final payload byte.
//
// Ports:
//   logic_clk, logic_rst        clock, asynchronous active-high reset
//   enable                      permits new frames to start
//   s_sample_tdata/tvalid/tready  sample word input stream
//   m_axis_tdata/tvalid/tready/tlast/tuser  payload byte output stream
//   seq_num                     sequence number of the next frame to start
//   busy                        a frame is in progress
module udp_sample_packetizer
    import udp_pkt_pkg::*;
#(
    parameter int SAMPLE_WIDTH      = 16,
    parameter int SAMPLES_PER_FRAME = 10
) (
    input  logic                    logic_clk,
    input  logic                    logic_rst,
    input  logic                    enable,
    input  logic [SAMPLE_WIDTH-1:0] s_sample_tdata,
    input  logic                    s_sample_tvalid,
    output logic                    s_sample_tready,
    output logic [7:0]              m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic [31:0]             seq_num,
    output logic                    busy
);

    localparam int SAMPLE_BYTES = SAMPLE_WIDTH / 8;
    localparam int BYTE_IDX_W   = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
    localparam int SAMPLE_IDX_W = (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;

    // Samples per frame recovered from the payload length so the framing
    // and the advertised UDP length can never disagree.
    localparam int unsigned PAYLOAD_BYTES = payload_len(SAMPLES_PER_FRAME, SAMPLE_BYTES);
    localparam int unsigned FRAME_SAMPLES = (PAYLOAD_BYTES - HDR_BYTES) / SAMPLE_BYTES;

    localparam logic [BYTE_IDX_W-1:0]   LAST_BYTE   = BYTE_IDX_W'(SAMPLE_BYTES - 1);
    localparam logic [SAMPLE_IDX_W-1:0] LAST_SAMPLE = SAMPLE_IDX_W'(FRAME_SAMPLES - 1);

    pkt_state_t                state;
    logic [SAMPLE_WIDTH-1:0]   sample_data;
    logic                      sample_valid;
    logic [1:0]                hdr_idx;
    logic [BYTE_IDX_W-1:0]     byte_idx;
    logic [SAMPLE_IDX_W-1:0]   sample_idx;

    logic       out_hs;
    logic       last_byte;
    logic       last_sample;
    logic       drain;
    logic       accept;
    logic [7:0] hdr_byte;
    logic [7:0] data_byte;

    assign out_hs      = m_axis_tvalid && m_axis_tready;
    assign last_byte   = (byte_idx == LAST_BYTE);
    assign last_sample = (sample_idx == LAST_SAMPLE);

    // The held sample leaves the register when its final byte is taken.
    assign drain  = (state == DATA) && sample_valid && m_axis_tready && last_byte;

    // Refill in the same cycle as a drain keeps the byte stream bubble-free.
    // Outside a frame, enable gates whether a new sample may be captured.
    assign s_sample_tready = !logic_rst && ((state != IDLE) || enable) &&
                             (!sample_valid || drain);
    assign accept          = s_sample_tvalid && s_sample_tready;

    assign busy         = (state != IDLE);
    assign m_axis_tuser = 1'b0;

    always_comb begin
        hdr_byte = seq_num[7:0];
        case (hdr_idx)
            2'd0:    hdr_byte = seq_num[31:24];
            2'd1:    hdr_byte = seq_num[23:16];
            2'd2:    hdr_byte = seq_num[15:8];
            default: hdr_byte = seq_num[7:0];
        endcase
    end

    // byte_idx 0 selects the most significant byte of the held sample.
    always_comb begin
        data_byte = '0;
        for (int b = 0; b < SAMPLE_BYTES; b++) begin
            if (byte_idx == BYTE_IDX_W'(SAMPLE_BYTES - 1 - b)) begin
                data_byte = sample_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        case (state)
            HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_byte;
            end
            DATA: begin
                m_axis_tvalid = sample_valid;
                m_axis_tdata  = data_byte;
                m_axis_tlast  = sample_valid && last_byte && last_sample;
            end
            default: ;
        endcase
    end

    // Sample word storage carries no reset; sample_valid qualifies it.
    always_ff @(posedge logic_clk) begin
        if (accept) begin
            sample_data <= s_sample_tdata;
        end
    end

    always_ff @(posedge logic_clk or posedge logic_rst) begin
        if (logic_rst) begin
            state        <= IDLE;
            sample_valid <= 1'b0;
            hdr_idx      <= '0;
            byte_idx     <= '0;
            sample_idx   <= '0;
            seq_num      <= '0;
        end else begin
            if (accept) begin
                sample_valid <= 1'b1;
            end else if (drain) begin
                sample_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (sample_valid && enable) begin
                        state <= HDR;
                    end
                end
                HDR: begin
                    if (out_hs) begin
                        if (hdr_idx == 2'd3) begin
                            hdr_idx <= '0;
                            state   <= DATA;
                        end else begin
                            hdr_idx <= hdr_idx + 2'd1;
                        end
                    end
                end
                DATA: begin
                    if (out_hs) begin
                        if (last_byte) begin
                            byte_idx <= '0;
                            if (last_sample) begin
                                sample_idx <= '0;
                                seq_num    <= seq_num + 32'd1;
                                state      <= IDLE;
                            end else begin
                                sample_idx <= sample_idx + 1'b1;
                            end
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_sample_packetizer.sv
module tb_udp_sample_packetizer;

    logic        logic_clk = 1'b0;
    logic        logic_rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] s_sample_tdata = '0;
    logic        s_sample_tvalid = 1'b0;
    logic        s_sample_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [31:0] seq_num;
    logic        busy;

    udp_sample_packetizer #(
        .SAMPLE_WIDTH(16),
        .SAMPLES_PER_FRAME(10)
    ) dut (
        .logic_clk(logic_clk),
        .logic_rst(logic_rst),
        .enable(enable),
        .s_sample_tdata(s_sample_tdata),
        .s_sample_tvalid(s_sample_tvalid),
        .s_sample_tready(s_sample_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser),
        .seq_num(seq_num),
        .busy(busy)
    );

    always #5 logic_clk = ~logic_clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] samp_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  cap_data[$];
    bit          cap_last[$];
    int          cap_cyc[$];
    int          stall_err, user_err, idle_in_frame, first_acc, first_vld, sent;
    bit          timed_out;

    function automatic void fill_samples(input logic [15:0] base, input logic [15:0] step,
                                         input int n);
        samp_q.delete();
        for (int k = 0; k < n; k++) samp_q.push_back(16'(base + 16'(k) * step));
    endfunction

    // Reference payload: big-endian sequence number, then samples MSB first.
    function automatic void build_exp(input int first_seq, input int nframes);
        logic [31:0] s;
        logic [15:0] w;
        exp_q.delete();
        for (int f = 0; f < nframes; f++) begin
            s = 32'(first_seq + f);
            exp_q.push_back(s[31:24]);
            exp_q.push_back(s[23:16]);
            exp_q.push_back(s[15:8]);
            exp_q.push_back(s[7:0]);
            for (int k = 0; k < 10; k++) begin
                w = samp_q[f*10 + k];
                exp_q.push_back(w[15:8]);
                exp_q.push_back(w[7:0]);
            end
        end
    endfunction

    task automatic apply_reset();
        @(negedge logic_clk);
        logic_rst = 1'b1;
        s_sample_tvalid = 1'b0;
        @(negedge logic_clk);
        logic_rst = 1'b0;
    endtask

    // Drives samp_q[0..n_samp-1] and collects output bytes until exp_bytes are
    // taken or max_cyc elapses. Inputs change on the falling edge; outputs are
    // observed 1 ns later, before the next rising edge.
    task automatic run(input int n_samp, input int exp_bytes, input bit rnd,
                       input int gap, input int en_drop_at, input int max_cyc);
        int         gap_cnt = 0;
        int         c = 0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        logic       prev_last = 1'b0;
        cap_data.delete(); cap_last.delete(); cap_cyc.delete();
        stall_err = 0; user_err = 0; idle_in_frame = 0;
        first_acc = -1; first_vld = -1; sent = 0; timed_out = 1'b0;
        while (cap_data.size() < exp_bytes) begin
            if (c >= max_cyc) begin
                timed_out = 1'b1;
                break;
            end
            if (en_drop_at >= 0 && sent >= en_drop_at) enable = 1'b0;
            s_sample_tvalid = (sent < n_samp) && (gap_cnt == 0);
            s_sample_tdata  = (sent < n_samp) ? samp_q[sent] : 16'h0000;
            m_axis_tready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data ||
                               m_axis_tlast !== prev_last)) stall_err++;
            if (m_axis_tuser !== 1'b0) user_err++;
            if (busy && !m_axis_tvalid) idle_in_frame++;
            if (m_axis_tvalid && first_vld < 0) first_vld = c;
            if (m_axis_tvalid && m_axis_tready) begin
                cap_data.push_back(m_axis_tdata);
                cap_last.push_back(m_axis_tlast);
                cap_cyc.push_back(c);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (gap_cnt > 0) gap_cnt--;
            if (s_sample_tvalid && s_sample_tready) begin
                if (first_acc < 0) first_acc = c;
                sent++;
                gap_cnt = gap;
            end
            @(negedge logic_clk);
            c++;
        end
        s_sample_tvalid = 1'b0;
        m_axis_tready   = 1'b1;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        s_sample_tvalid = 1'b1;
        s_sample_tdata = 16'hBEEF;
        m_axis_tready = 1'b1;
        logic_rst = 1'b1;
        @(negedge logic_clk);
        #1;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b expected 0", m_axis_tlast); end
        checks++; if (m_axis_tuser !== 1'b0) begin errors++; $display("FAIL rst_tuser: got %b expected 0", m_axis_tuser); end
        checks++; if (m_axis_tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata: got %h expected 00", m_axis_tdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (seq_num !== 32'h0) begin errors++; $display("FAIL rst_seq: got %h expected 0", seq_num); end
        checks++; if (s_sample_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready: got %b expected 0", s_sample_tready); end
        @(negedge logic_clk);
        s_sample_tvalid = 1'b0;
        logic_rst = 1'b0;
        #1;
        checks++; if (s_sample_tready !== 1'b1) begin errors++; $display("FAIL post_rst_s_tready: got %b expected 1", s_sample_tready); end
        @(negedge logic_clk);
    endtask

    task automatic test_single_frame();
        fill_samples(16'h0102, 16'h0202, 10);
        build_exp(0, 1);
        run(10, 24, 1'b0, 0, -1, 200);
        checks++; if (timed_out) begin errors++; $display("FAIL single_timeout: got %0d bytes expected 24", cap_data.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= cap_data.size() || cap_data[i] !== exp_q[i] || cap_last[i] !== (i % 24 == 23)) begin
                errors++;
                $display("FAIL single_byte[%0d]: got %h last %b expected %h last %b", i,
                         (i < cap_data.size()) ? cap_data[i] : 8'hxx,
                         (i < cap_last.size()) ? cap_last[i] : 1'b0, exp_q[i], (i % 24 == 23));
            end
        end
        checks++; if (first_vld - first_acc != 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", first_vld - first_acc); end
        checks++; if (seq_num !== 32'd1) begin errors++; $display("FAIL single_seq: got %0d expected 1", seq_num); end
        checks++; if (user_err != 0) begin errors++; $display("FAIL single_tuser: got %0d nonzero cycles expected 0", user_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        enable = 1'b1;
        fill_samples(16'h0102, 16'h0202, 30);
        build_exp(0, 3);
        run(30, 72, 1'b0, 0, -1, 300);
        checks++; if (timed_out) begin errors++; $display("FAIL b2b_timeout: got %0d bytes expected 72", cap_data.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= cap_data.size() || cap_data[i] !== exp_q[i] || cap_last[i] !== (i % 24 == 23)) begin
                errors++;
                $display("FAIL b2b_byte[%0d]: got %h last %b expected %h last %b", i,
                         (i < cap_data.size()) ? cap_data[i] : 8'hxx,
                         (i < cap_last.size()) ? cap_last[i] : 1'b0, exp_q[i], (i % 24 == 23));
            end
        end
        if (cap_cyc.size() == 72) begin
            checks++; if (cap_cyc[23] - cap_cyc[0] != 23) begin errors++; $display("FAIL b2b_frame0_span: got %0d expected 23", cap_cyc[23] - cap_cyc[0]); end
            checks++; if (cap_cyc[24] - cap_cyc[23] != 2) begin errors++; $display("FAIL b2b_gap0: got %0d expected 2", cap_cyc[24] - cap_cyc[23]); end
            checks++; if (cap_cyc[48] - cap_cyc[47] != 2) begin errors++; $display("FAIL b2b_gap1: got %0d expected 2", cap_cyc[48] - cap_cyc[47]); end
        end
        checks++; if (seq_num !== 32'd3) begin errors++; $display("FAIL b2b_seq: got %0d expected 3", seq_num); end
    endtask

    task automatic test_stall();
        apply_reset();
        enable = 1'b1;
        fill_samples(16'hA0B1, 16'h1357, 20);
        build_exp(0, 2);
        run(20, 48, 1'b1, 0, -1, 800);
        checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout: got %0d bytes expected 48", cap_data.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= cap_data.size() || cap_data[i] !== exp_q[i] || cap_last[i] !== (i % 24 == 23)) begin
                errors++;
                $display("FAIL stall_byte[%0d]: got %h last %b expected %h last %b", i,
                         (i < cap_data.size()) ? cap_data[i] : 8'hxx,
                         (i < cap_last.size()) ? cap_last[i] : 1'b0, exp_q[i], (i % 24 == 23));
            end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL stall_stability: got %0d unstable cycles expected 0", stall_err); end
        checks++; if (sent != 20) begin errors++; $display("FAIL stall_samples: got %0d accepted expected 20", sent); end
        checks++; if (seq_num !== 32'd2) begin errors++; $display("FAIL stall_seq: got %0d expected 2", seq_num); end
    endtask

    task automatic test_gaps();
        apply_reset();
        enable = 1'b1;
        fill_samples(16'hFF00, 16'h0111, 10);
        build_exp(0, 1);
        run(10, 24, 1'b0, 5, -1, 400);
        checks++; if (timed_out) begin errors++; $display("FAIL gap_timeout: got %0d bytes expected 24", cap_data.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= cap_data.size() || cap_data[i] !== exp_q[i] || cap_last[i] !== (i % 24 == 23)) begin
                errors++;
                $display("FAIL gap_byte[%0d]: got %h last %b expected %h last %b", i,
                         (i < cap_data.size()) ? cap_data[i] : 8'hxx,
                         (i < cap_last.size()) ? cap_last[i] : 1'b0, exp_q[i], (i % 24 == 23));
            end
        end
        checks++; if (idle_in_frame < 5) begin errors++; $display("FAIL gap_tvalid_low: got %0d idle cycles expected at least 5", idle_in_frame); end
        checks++; if (seq_num !== 32'd1) begin errors++; $display("FAIL gap_seq: got %0d expected 1", seq_num); end
    endtask

    task automatic test_enable_drop();
        apply_reset();
        enable = 1'b1;
        fill_samples(16'h1234, 16'h1111, 10);
        build_exp(0, 1);
        run(10, 24, 1'b0, 0, 4, 300);
        checks++; if (timed_out) begin errors++; $display("FAIL en_timeout: got %0d bytes expected 24", cap_data.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= cap_data.size() || cap_data[i] !== exp_q[i] || cap_last[i] !== (i % 24 == 23)) begin
                errors++;
                $display("FAIL en_byte[%0d]: got %h last %b expected %h last %b", i,
                         (i < cap_data.size()) ? cap_data[i] : 8'hxx,
                         (i < cap_last.size()) ? cap_last[i] : 1'b0, exp_q[i], (i % 24 == 23));
            end
        end
        // With enable low in IDLE, an offered sample must be refused.
        s_sample_tdata = 16'hDEAD;
        s_sample_tvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (s_sample_tready !== 1'b0) begin errors++; $display("FAIL en_refuse[%0d]: got tready %b expected 0", k, s_sample_tready); end
            checks++; if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL en_idle[%0d]: got busy %b tvalid %b expected 0 0", k, busy, m_axis_tvalid); end
            @(negedge logic_clk);
        end
        s_sample_tvalid = 1'b0;
        enable = 1'b1;
        fill_samples(16'h5A01, 16'h0203, 10);
        build_exp(1, 1);
        run(10, 24, 1'b0, 0, -1, 200);
        checks++; if (timed_out) begin errors++; $display("FAIL en_f1_timeout: got %0d bytes expected 24", cap_data.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= cap_data.size() || cap_data[i] !== exp_q[i] || cap_last[i] !== (i % 24 == 23)) begin
                errors++;
                $display("FAIL en_f1_byte[%0d]: got %h last %b expected %h last %b", i,
                         (i < cap_data.size()) ? cap_data[i] : 8'hxx,
                         (i < cap_last.size()) ? cap_last[i] : 1'b0, exp_q[i], (i % 24 == 23));
            end
        end
        checks++; if (seq_num !== 32'd2) begin errors++; $display("FAIL en_seq: got %0d expected 2", seq_num); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        enable = 1'b1;
        fill_samples(16'h0A0B, 16'h0101, 10);
        run(10, 24, 1'b0, 0, -1, 200);
        checks++; if (seq_num !== 32'd1) begin errors++; $display("FAIL mid_pre_seq: got %0d expected 1", seq_num); end
        fill_samples(16'h7700, 16'h0011, 10);
        run(10, 10, 1'b0, 0, -1, 200);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        #2;
        logic_rst = 1'b1;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL mid_tlast: got %b expected 0", m_axis_tlast); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (seq_num !== 32'd0) begin errors++; $display("FAIL mid_seq: got %0d expected 0", seq_num); end
        checks++; if (s_sample_tready !== 1'b0) begin errors++; $display("FAIL mid_s_tready: got %b expected 0", s_sample_tready); end
        @(negedge logic_clk);
        logic_rst = 1'b0;
        fill_samples(16'hC3C4, 16'h0102, 10);
        build_exp(0, 1);
        run(10, 24, 1'b0, 0, -1, 200);
        checks++; if (timed_out) begin errors++; $display("FAIL mid_timeout: got %0d bytes expected 24", cap_data.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= cap_data.size() || cap_data[i] !== exp_q[i] || cap_last[i] !== (i % 24 == 23)) begin
                errors++;
                $display("FAIL mid_byte[%0d]: got %h last %b expected %h last %b", i,
                         (i < cap_data.size()) ? cap_data[i] : 8'hxx,
                         (i < cap_last.size()) ? cap_last[i] : 1'b0, exp_q[i], (i % 24 == 23));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_gaps();
        test_enable_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
